// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encodings on exe_op and the controller state encoding.
package muldiv_pkg;

    // exe_op encodings; codes 6 and 7 are reserved and behave as no-ops.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply and restoring
// division, one bit per step. Operands arrive as magnitudes; sign handling
// lives in the parent. After W steps {o_hi,o_lo} holds the product, or
// o_hi the remainder and o_lo the quotient.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_mul_step,
    input  logic         i_div_step,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo,
    output logic         o_last
);

    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic [W-1:0]     r_b;
    logic [CNT_W-1:0] r_cnt;

    logic [W:0]       w_mul_sum;
    logic [W:0]       w_div_shift;
    logic             w_div_ge;
    logic [W-1:0]     w_div_sub;
    logic [W-1:0]     w_div_rem;

    // Multiply step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        if (r_lo[0]) begin
            w_mul_sum = {1'b0, r_hi} + {1'b0, r_b};
        end else begin
            w_mul_sum = {1'b0, r_hi};
        end
    end

    // Divide step: shift in the next dividend bit and trial-subtract the divisor.
    // When the trial succeeds the difference is below the divisor, so the low
    // W bits of the modular subtraction are exact.
    always_comb begin
        w_div_shift = {r_hi, r_lo[W-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_sub   = w_div_shift[W-1:0] - r_b;
        if (w_div_ge) begin
            w_div_rem = w_div_sub;
        end else begin
            w_div_rem = w_div_shift[W-1:0];
        end
    end

    // Accumulator, shift register and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
            r_cnt <= CNT_W'(W);
        end else if (i_mul_step) begin
            r_hi  <= w_mul_sum[W:1];
            r_lo  <= {w_mul_sum[0], r_lo[W-1:1]};
            r_cnt <= r_cnt - CNT_W'(1);
        end else if (i_div_step) begin
            r_hi  <= w_div_rem;
            r_lo  <= {r_lo[W-2:0], w_div_ge};
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_hi  <= r_hi;
            r_lo  <= r_lo;
            r_b   <= r_b;
            r_cnt <= r_cnt;
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage multiply/divide unit. Owns the architectural HI/LO
// registers, sequences the iterative core, applies sign correction in the
// FIX cycle and commits {HI,LO} only when an operation completes unflushed.
module execute_muldiv
    import muldiv_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         exe_start,
    input  logic [2:0]   exe_op,
    input  logic [W-1:0] exe_rs_in,
    input  logic [W-1:0] exe_rt_in,
    input  logic         exe_flush,
    output logic         exe_busy,
    output logic         exe_done,
    output logic         exe_div_zero,
    output logic [W-1:0] exe_hi_out,
    output logic [W-1:0] exe_lo_out
);

    // Magnitude of a value that may be interpreted as two's complement.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic is_signed);
        if (is_signed && v[W-1]) begin
            mag = -v;
        end else begin
            mag = v;
        end
    endfunction

    state_e       r_state;
    state_e       w_state_nxt;
    logic         r_busy;
    logic         r_done;
    logic         r_div_zero;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic         r_is_div;
    logic         r_neg_res;
    logic         r_neg_rem;

    logic         w_is_signed;
    logic         w_load;
    logic         w_mul_step;
    logic         w_div_step;
    logic         w_hi_we;
    logic         w_lo_we;
    logic [W-1:0] w_hi_d;
    logic [W-1:0] w_lo_d;
    logic         w_done_nxt;
    logic         w_dz_nxt;
    logic [W-1:0] w_core_hi;
    logic [W-1:0] w_core_lo;
    logic         w_last;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0] w_quo_fix;
    logic [W-1:0] w_rem_fix;

    assign w_is_signed = (exe_op == OP_MULT) || (exe_op == OP_DIV);

    muldiv_core #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_a        (mag(exe_rs_in, w_is_signed)),
        .i_b        (mag(exe_rt_in, w_is_signed)),
        .i_mul_step (w_mul_step),
        .i_div_step (w_div_step),
        .o_hi       (w_core_hi),
        .o_lo       (w_core_lo),
        .o_last     (w_last)
    );

    // Sign correction of the unsigned core result for the FIX cycle.
    always_comb begin
        w_prod = {w_core_hi, w_core_lo};
        if (r_neg_res) begin
            w_prod_fix = -w_prod;
            w_quo_fix  = -w_core_lo;
        end else begin
            w_prod_fix = w_prod;
            w_quo_fix  = w_core_lo;
        end
        if (r_neg_rem) begin
            w_rem_fix = -w_core_hi;
        end else begin
            w_rem_fix = w_core_hi;
        end
    end

    // Next-state, datapath control and HI/LO write decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_mul_step  = 1'b0;
        w_div_step  = 1'b0;
        w_hi_we     = 1'b0;
        w_lo_we     = 1'b0;
        w_hi_d      = r_hi;
        w_lo_d      = r_lo;
        w_done_nxt  = 1'b0;
        w_dz_nxt    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (exe_flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (exe_start) begin
                    case (exe_op)
                        OP_MULT, OP_MULTU: begin
                            w_load      = 1'b1;
                            w_state_nxt = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (exe_rt_in == '0) begin
                                w_state_nxt = ST_DONE;
                                w_done_nxt  = 1'b1;
                                w_dz_nxt    = 1'b1;
                            end else begin
                                w_load      = 1'b1;
                                w_state_nxt = ST_DIV;
                            end
                        end
                        OP_MTHI: begin
                            w_hi_we = 1'b1;
                            w_hi_d  = exe_rs_in;
                        end
                        OP_MTLO: begin
                            w_lo_we = 1'b1;
                            w_lo_d  = exe_rs_in;
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (exe_flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_mul_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_FIX;
                    end else begin
                        w_state_nxt = ST_MUL;
                    end
                end
            end
            ST_DIV: begin
                if (exe_flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_div_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_FIX;
                    end else begin
                        w_state_nxt = ST_DIV;
                    end
                end
            end
            ST_FIX: begin
                if (exe_flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hi_we     = 1'b1;
                    w_lo_we     = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                    if (r_is_div) begin
                        w_hi_d = w_rem_fix;
                        w_lo_d = w_quo_fix;
                    end else begin
                        w_hi_d = w_prod_fix[2*W-1:W];
                        w_lo_d = w_prod_fix[W-1:0];
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done/div_zero status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt == ST_MUL) || (w_state_nxt == ST_DIV) ||
                          (w_state_nxt == ST_FIX);
            r_done     <= w_done_nxt;
            r_div_zero <= w_dz_nxt;
        end
    end

    // Operation kind and sign flags captured when an iterative op starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (w_load) begin
            r_is_div  <= (exe_op == OP_DIV) || (exe_op == OP_DIVU);
            r_neg_res <= w_is_signed && (exe_rs_in[W-1] ^ exe_rt_in[W-1]);
            r_neg_rem <= w_is_signed && exe_rs_in[W-1];
        end else begin
            r_is_div  <= r_is_div;
            r_neg_res <= r_neg_res;
            r_neg_rem <= r_neg_rem;
        end
    end

    // Architectural HI/LO registers; only committed values ever appear here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_hi_we) begin
                r_hi <= w_hi_d;
            end else begin
                r_hi <= r_hi;
            end
            if (w_lo_we) begin
                r_lo <= w_lo_d;
            end else begin
                r_lo <= r_lo;
            end
        end
    end

    assign exe_busy     = r_busy;
    assign exe_done     = r_done;
    assign exe_div_zero = r_div_zero;
    assign exe_hi_out   = r_hi;
    assign exe_lo_out   = r_lo;

endmodule
